// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed driver for a bank of DIGITS seven-segment
//            digits. It has a scan prescaler, one-hot digit scanning and
//            frame-synchronous (tear-free) loading through shadow registers.
//            It also provides leading-zero blanking, per-digit decimal points,
//            a lamp test and selectable pin polarity.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DIGITS     : number of digits (1..8); digit 0 is least significant
//   SCAN_DIV   : clocks per digit slot (>= 2)
//   ACTIVE_LOW : 1 inverts sg7, sg7_dp and digit_sel at the pins
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   enable            : 0 blanks all outputs (scanning keeps running)
//   seg7all_on        : lamp test, overrides enable
//   blank_lz          : leading-zero blanking
//   load              : strobe capturing value / dp_in into the pending regs
//   value, dp_in      : packed nibbles and decimal points, index i -> digit i
//   sg7, sg7_dp       : segments {g,f,e,d,c,b,a} and decimal point
//   digit_sel         : one-hot digit enable
//   pend              : loaded data waiting for the next frame boundary
//   frame_done        : one-cycle pulse after each frame wrap
// Build option
//   SEG7_HEX_EN       : when defined, nibbles A..F show A b C d E F;
//                       otherwise they decode to blank.
// ============================================================================
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  seg7all_on,
    input  logic                  blank_lz,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            sg7,
    output logic                  sg7_dp,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  pend,
    output logic                  frame_done
);

    localparam int c_PCNT_W = $clog2(SCAN_DIV);
    localparam int c_IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DIGITS - 1);
    localparam logic                c_INV       = (ACTIVE_LOW != 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PCNT_W-1:0]  r_pcnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [4*DIGITS-1:0]  r_pend_val;
    logic [DIGITS-1:0]    r_pend_dp;
    logic [4*DIGITS-1:0]  r_disp_val;
    logic [DIGITS-1:0]    r_disp_dp;
    logic                 r_pend;
    logic                 r_frame_done;
    logic [6:0]           r_sg7;
    logic                 r_sg7_dp;
    logic [DIGITS-1:0]    r_digit_sel;

    logic                 w_tick;
    logic                 w_wrap;
    logic [3:0]           w_cur_nib;
    logic                 w_cur_dp;
    logic                 w_cur_blank;
    logic [DIGITS-1:0]    w_blank;
    logic [6:0]           w_sg7_next;
    logic                 w_dp_next;
    logic [DIGITS-1:0]    w_sel_next;

    assign w_tick = (r_pcnt == c_PCNT_LAST);
    assign w_wrap = w_tick && (r_idx == c_IDX_LAST);

    // ------------------------------------------------------------------
    // Segment decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
`ifdef SEG7_HEX_EN
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
`endif
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Leading-zero blanking: walk down from the top digit; a digit is
    // blanked while it and everything above it are zero. Digit 0 is
    // never part of the walk, so a value of zero still shows "0".
    // ------------------------------------------------------------------
    always_comb begin
        logic zero_run;
        w_blank  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (r_disp_val[i*4 +: 4] == 4'h0);
            w_blank[i] = blank_lz && zero_run;
        end
    end

    // Select the nibble, decimal point and blank flag of the current slot.
    always_comb begin
        w_cur_nib   = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_cur_nib   = r_disp_val[i*4 +: 4];
                w_cur_dp    = r_disp_dp[i];
                w_cur_blank = w_blank[i];
            end
        end
    end

    // Output priority: lamp test, then enable, then normal scanning.
    always_comb begin
        w_sg7_next = 7'h00;
        w_dp_next  = 1'b0;
        w_sel_next = '0;
        if (seg7all_on) begin
            w_sg7_next = 7'h7F;
            w_dp_next  = 1'b1;
            w_sel_next = '1;
        end else if (enable) begin
            w_sel_next = DIGITS'(1) << r_idx;
            w_sg7_next = w_cur_blank ? 7'h00 : f_decode(w_cur_nib);
            w_dp_next  = w_cur_dp;
        end
    end

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_idx  <= '0;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow / display registers. A load coinciding with a wrap still
    // promotes the older pending data; the new data then waits a frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_pend       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
            end
            if (w_wrap && r_pend) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end
            if (load) begin
                r_pend <= 1'b1;
            end else if (w_wrap) begin
                r_pend <= 1'b0;
            end
            r_frame_done <= w_wrap;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs (logical polarity)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sg7       <= 7'h00;
            r_sg7_dp    <= 1'b0;
            r_digit_sel <= '0;
        end else begin
            r_sg7       <= w_sg7_next;
            r_sg7_dp    <= w_dp_next;
            r_digit_sel <= w_sel_next;
        end
    end

    assign sg7        = r_sg7 ^ {7{c_INV}};
    assign sg7_dp     = r_sg7_dp ^ c_INV;
    assign digit_sel  = r_digit_sel ^ {DIGITS{c_INV}};
    assign pend       = r_pend;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Directed, self-checking bench for seg7_scan_driver
//            (DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        seg7all_on;
    logic        blank_lz;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  sg7;
    logic        sg7_dp;
    logic [3:0]  digit_sel;
    logic        pend;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;   // clock edges since reset was released

    seg7_scan_driver #(
        .DIGITS     (4),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .seg7all_on (seg7all_on),
        .blank_lz   (blank_lz),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .sg7        (sg7),
        .sg7_dp     (sg7_dp),
        .digit_sel  (digit_sel),
        .pend       (pend),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (sg7 !== 7'h00) begin n_err++; $display("FAIL reset_sg7 got=%h exp=00", sg7); end
        n_cmp++; if (sg7_dp !== 1'b0) begin n_err++; $display("FAIL reset_dp got=%b exp=0", sg7_dp); end
        n_cmp++; if (digit_sel !== 4'b0000) begin n_err++; $display("FAIL reset_sel got=%b exp=0000", digit_sel); end
        n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL reset_pend got=%b exp=0", pend); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_sel;
        logic       exp_fd;
        do_reset();
        for (int k = 1; k <= 33; k++) begin
            step();
            exp_sel = 4'(1 << (((cyc - 1) / 4) % 4));
            exp_fd  = (cyc % 16 == 0);
            n_cmp++; if (digit_sel !== exp_sel) begin n_err++; $display("FAIL scan_sel cyc=%0d got=%b exp=%b", cyc, digit_sel, exp_sel); end
            n_cmp++; if (sg7 !== 7'h3F) begin n_err++; $display("FAIL scan_sg7 cyc=%0d got=%h exp=3F", cyc, sg7); end
            n_cmp++; if (frame_done !== exp_fd) begin n_err++; $display("FAIL scan_frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd); end
        end
    endtask

    task automatic test_load();
        logic [6:0] exp_seg [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        logic [3:0] exp_sel;
        do_reset();
        repeat (5) step();
        value = 16'h1234;
        load  = 1'b1;
        step();
        load  = 1'b0;
        while (cyc < 16) begin
            n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL load_pend cyc=%0d got=%b exp=1", cyc, pend); end
            n_cmp++; if (sg7 !== 7'h3F) begin n_err++; $display("FAIL load_early cyc=%0d got=%h exp=3F", cyc, sg7); end
            step();
        end
        n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL load_pend_clear got=%b exp=0", pend); end
        n_cmp++; if (sg7 !== 7'h3F) begin n_err++; $display("FAIL load_wrap_old got=%h exp=3F", sg7); end
        for (int k = 0; k < 16; k++) begin
            step();
            exp_sel = 4'(1 << (k / 4));
            n_cmp++; if (sg7 !== exp_seg[k/4]) begin n_err++; $display("FAIL load_show cyc=%0d got=%h exp=%h", cyc, sg7, exp_seg[k/4]); end
            n_cmp++; if (digit_sel !== exp_sel) begin n_err++; $display("FAIL load_sel cyc=%0d got=%b exp=%b", cyc, digit_sel, exp_sel); end
        end
    endtask

    task automatic test_blank();
        logic [6:0] exp_a [4] = '{7'h3F, 7'h6D, 7'h00, 7'h00};
        logic       exp_dp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        blank_lz = 1'b1;
        value    = 16'h0050;
        dp_in    = 4'b0100;
        load     = 1'b1;
        step();
        load     = 1'b0;
        dp_in    = 4'b0000;
        while (cyc < 16) step();
        for (int k = 0; k < 16; k++) begin
            step();
            n_cmp++; if (sg7 !== exp_a[k/4]) begin n_err++; $display("FAIL blank_0050 cyc=%0d got=%h exp=%h", cyc, sg7, exp_a[k/4]); end
            n_cmp++; if (sg7_dp !== exp_dp[k/4]) begin n_err++; $display("FAIL blank_dp cyc=%0d got=%b exp=%b", cyc, sg7_dp, exp_dp[k/4]); end
        end
        value = 16'h0000;
        load  = 1'b1;
        step();
        load  = 1'b0;
        while (cyc < 48) step();
        for (int k = 0; k < 16; k++) begin
            step();
            n_cmp++; if (sg7 !== ((k < 4) ? 7'h3F : 7'h00)) begin n_err++; $display("FAIL blank_0000 cyc=%0d got=%h", cyc, sg7); end
            n_cmp++; if (sg7_dp !== 1'b0) begin n_err++; $display("FAIL blank_dp0 cyc=%0d got=%b exp=0", cyc, sg7_dp); end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_lamp();
        do_reset();
        repeat (3) step();
        enable     = 1'b0;
        seg7all_on = 1'b1;
        step();
        n_cmp++; if (digit_sel !== 4'b1111) begin n_err++; $display("FAIL lamp_sel got=%b exp=1111", digit_sel); end
        n_cmp++; if (sg7 !== 7'h7F) begin n_err++; $display("FAIL lamp_sg7 got=%h exp=7F", sg7); end
        n_cmp++; if (sg7_dp !== 1'b1) begin n_err++; $display("FAIL lamp_dp got=%b exp=1", sg7_dp); end
        seg7all_on = 1'b0;
        step();
        n_cmp++; if (digit_sel !== 4'b0000) begin n_err++; $display("FAIL disable_sel got=%b exp=0000", digit_sel); end
        n_cmp++; if (sg7 !== 7'h00) begin n_err++; $display("FAIL disable_sg7 got=%h exp=00", sg7); end
        n_cmp++; if (sg7_dp !== 1'b0) begin n_err++; $display("FAIL disable_dp got=%b exp=0", sg7_dp); end
        enable = 1'b1;
    endtask

    task automatic test_hex();
`ifdef SEG7_HEX_EN
        logic [6:0] exp_h [4] = '{7'h5E, 7'h39, 7'h7C, 7'h77};
`else
        logic [6:0] exp_h [4] = '{7'h00, 7'h00, 7'h00, 7'h00};
`endif
        do_reset();
        value = 16'hABCD;
        load  = 1'b1;
        step();
        load  = 1'b0;
        while (cyc < 16) step();
        for (int k = 0; k < 16; k++) begin
            step();
            n_cmp++; if (sg7 !== exp_h[k/4]) begin n_err++; $display("FAIL hex cyc=%0d got=%h exp=%h", cyc, sg7, exp_h[k/4]); end
        end
    endtask

    task automatic test_load_hold();
        do_reset();
        load  = 1'b1;
        value = 16'h0005; step();
        value = 16'h0006; step();
        value = 16'h0007; step();
        load  = 1'b0;
        n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL hold_pend got=%b exp=1", pend); end
        while (cyc < 17) step();
        n_cmp++; if (sg7 !== 7'h07) begin n_err++; $display("FAIL hold_last got=%h exp=07", sg7); end
        n_cmp++; if (digit_sel !== 4'b0001) begin n_err++; $display("FAIL hold_sel got=%b exp=0001", digit_sel); end
        while (cyc < 21) step();
        n_cmp++; if (sg7 !== 7'h3F) begin n_err++; $display("FAIL hold_digit1 got=%h exp=3F", sg7); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        value = 16'h2222;
        load  = 1'b1;
        step();
        load  = 1'b0;
        while (cyc < 15) step();
        value = 16'h1111;
        load  = 1'b1;
        step();                      // this edge is the frame wrap
        load  = 1'b0;
        n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL b2b_pend_wrap got=%b exp=1", pend); end
        for (int k = 0; k < 16; k++) begin
            step();
            n_cmp++; if (sg7 !== 7'h5B) begin n_err++; $display("FAIL b2b_first cyc=%0d got=%h exp=5B", cyc, sg7); end
            n_cmp++; if (pend !== (cyc < 32)) begin n_err++; $display("FAIL b2b_pend cyc=%0d got=%b", cyc, pend); end
        end
        for (int k = 0; k < 16; k++) begin
            step();
            n_cmp++; if (sg7 !== 7'h06) begin n_err++; $display("FAIL b2b_second cyc=%0d got=%h exp=06", cyc, sg7); end
        end
        // Reset in the middle of a frame with data pending.
        repeat (4) step();
        value = 16'h3333;
        load  = 1'b1;
        step();
        load  = 1'b0;
        n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL midrst_pend_before got=%b exp=1", pend); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (sg7 !== 7'h00) begin n_err++; $display("FAIL midrst_sg7 got=%h exp=00", sg7); end
        n_cmp++; if (digit_sel !== 4'b0000) begin n_err++; $display("FAIL midrst_sel got=%b exp=0000", digit_sel); end
        n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL midrst_pend got=%b exp=0", pend); end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        step();
        n_cmp++; if (digit_sel !== 4'b0001) begin n_err++; $display("FAIL midrst_restart got=%b exp=0001", digit_sel); end
        while (cyc < 17) step();
        n_cmp++; if (sg7 !== 7'h3F) begin n_err++; $display("FAIL midrst_discard got=%h exp=3F", sg7); end
        n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL midrst_pend_after got=%b exp=0", pend); end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        seg7all_on = 1'b0;
        blank_lz   = 1'b0;
        load       = 1'b0;
        value      = 16'h0000;
        dp_in      = 4'b0000;

        test_reset();
        test_scan();
        test_load();
        test_blank();
        test_lamp();
        test_hex();
        test_load_hold();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
